// File: rtl/sb_cargo_manager.sv
// Cargo manager: tracks collected blocks in a small slot table, sequences the
// arm/gripper servos for pick and drop, and hands PICK/DROP messages to the UART
// formatter over a valid/ready handshake.
module sb_cargo_manager #(
    parameter int unsigned NUM_SLOTS  = 3,
    parameter int unsigned NODE_W     = 5,
    parameter int unsigned SERVO_WAIT = 40000000,
    parameter int unsigned DUMP_W     = 17,
    parameter int unsigned DUMP_M     = 7,
    parameter int unsigned DUMP_D     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pick_req,
    input  logic [2:0]        pick_color,
    input  logic [7:0]        pick_city,
    output logic              pick_ack,
    input  logic              drop_req,
    input  logic [NODE_W-1:0] drop_node,
    output logic              drop_ack,
    output logic              err,
    output logic              busy,
    output logic [3:0]        count,
    output logic              full,
    output logic              empty,
    output logic [NODE_W-1:0] next_dump,
    output logic [1:0]        cmd_arm,
    output logic [1:0]        cmd_grip,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              msg_kind,
    output logic [7:0]        msg_city,
    output logic [7:0]        msg_type
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] TyW = 2'd0;
    localparam logic [1:0] TyM = 2'd1;
    localparam logic [1:0] TyD = 2'd2;

    localparam logic [1:0] ArmUp     = 2'b01;
    localparam logic [1:0] ArmDown   = 2'b10;
    localparam logic [1:0] GripOpen  = 2'b10;
    localparam logic [1:0] GripClose = 2'b11;

    typedef enum logic [3:0] {
        StIdle, StPLower, StPGrip, StPLift, StPMsg,
        StDLower, StDRelease, StDLift, StDMsg
    } state_e;

    function automatic logic [NODE_W-1:0] dump_of(input logic [1:0] ty);
        case (ty)
            TyW:     dump_of = NODE_W'(DUMP_W);
            TyM:     dump_of = NODE_W'(DUMP_M);
            default: dump_of = NODE_W'(DUMP_D);
        endcase
    endfunction

    function automatic logic [7:0] ascii_of(input logic [1:0] ty);
        case (ty)
            TyW:     ascii_of = 8'h57;  // "W"
            TyM:     ascii_of = 8'h4D;  // "M"
            default: ascii_of = 8'h44;  // "D"
        endcase
    endfunction

    state_e                        state_q, state_d;
    logic [31:0]                   cnt_q, cnt_d;
    logic [1:0]                    arm_q, arm_d, grip_q, grip_d;
    logic [NUM_SLOTS-1:0]          valid_q, valid_d;
    logic [NUM_SLOTS-1:0][1:0]     ty_q, ty_d;
    logic [NUM_SLOTS-1:0][7:0]     city_q, city_d;
    logic [1:0]                    pty_q, pty_d;
    logic [7:0]                    pcity_q, pcity_d;
    logic [NODE_W-1:0]             dnode_q, dnode_d;
    logic                          err_q, err_d, pack_q, pack_d, dack_q, dack_d;
    logic [3:0]                    count_q, count_d;
    logic                          full_q, full_d, empty_q, empty_d;
    logic [NODE_W-1:0]             ndump_q, ndump_d;

    logic                          col_ok;
    logic [1:0]                    col_ty;
    logic                          step_done;
    logic [NUM_SLOTS-1:0]          req_match, cur_match, rest_match;
    logic [IDX_W-1:0]              free_idx, msg_idx;

    assign step_done = (cnt_q == 32'(SERVO_WAIT - 1));

    // Colour decode, slot matching and lowest-index selection.
    always_comb begin
        col_ok = 1'b1;
        col_ty = TyW;
        case (pick_color)
            3'b001:  col_ty = TyW;
            3'b100:  col_ty = TyM;
            3'b010:  col_ty = TyD;
            default: col_ok = 1'b0;
        endcase
        free_idx = '0;
        msg_idx  = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            req_match[i] = valid_q[i] && (dump_of(ty_q[i]) == drop_node);
            cur_match[i] = valid_q[i] && (dump_of(ty_q[i]) == dnode_q);
            // Descending loop: last hit is the lowest index.
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (cur_match[i]) msg_idx = IDX_W'(i);
        end
        rest_match          = cur_match;
        rest_match[msg_idx] = 1'b0;
    end

    // Next-state, servo commands, slot table updates and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        arm_d   = arm_q;
        grip_d  = grip_q;
        valid_d = valid_q;
        ty_d    = ty_q;
        city_d  = city_q;
        pty_d   = pty_q;
        pcity_d = pcity_q;
        dnode_d = dnode_q;
        err_d   = 1'b0;
        pack_d  = 1'b0;
        dack_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (drop_req) begin
                    if (|req_match) begin
                        state_d = StDLower;
                        dnode_d = drop_node;
                        arm_d   = ArmDown;
                    end else begin
                        err_d  = 1'b1;
                        dack_d = 1'b1;
                    end
                end else if (pick_req) begin
                    if (full_q || !col_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StPLower;
                        pty_d   = col_ty;
                        pcity_d = pick_city;
                        arm_d   = ArmDown;
                        grip_d  = GripOpen;
                    end
                end
            end
            StPLower: if (step_done) begin
                state_d = StPGrip;
                grip_d  = GripClose;
            end
            StPGrip: if (step_done) begin
                state_d = StPLift;
                arm_d   = ArmUp;
            end
            StPLift: if (step_done) state_d = StPMsg;
            StPMsg: if (msg_ready) begin
                valid_d[free_idx] = 1'b1;
                ty_d[free_idx]    = pty_q;
                city_d[free_idx]  = pcity_q;
                state_d           = StIdle;
                pack_d            = 1'b1;
            end
            StDLower: if (step_done) begin
                state_d = StDRelease;
                grip_d  = GripOpen;
            end
            StDRelease: if (step_done) begin
                state_d = StDLift;
                arm_d   = ArmUp;
            end
            StDLift: if (step_done) state_d = StDMsg;
            StDMsg: if (msg_ready) begin
                valid_d[msg_idx] = 1'b0;
                if (rest_match == '0) begin
                    state_d = StIdle;
                    dack_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Occupancy flags derived from the post-update slot table.
    always_comb begin
        count_d = '0;
        ndump_d = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            count_d = count_d + 4'(valid_d[i]);
            if (valid_d[i]) ndump_d = dump_of(ty_d[i]);
        end
        full_d  = (count_d == 4'(NUM_SLOTS));
        empty_d = (count_d == 4'd0);
    end

    // State, slot table and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            arm_q   <= ArmUp;
            grip_q  <= GripOpen;
            valid_q <= '0;
            ty_q    <= '0;
            city_q  <= '0;
            pty_q   <= TyW;
            pcity_q <= '0;
            dnode_q <= '0;
            err_q   <= 1'b0;
            pack_q  <= 1'b0;
            dack_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ndump_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            grip_q  <= grip_d;
            valid_q <= valid_d;
            ty_q    <= ty_d;
            city_q  <= city_d;
            pty_q   <= pty_d;
            pcity_q <= pcity_d;
            dnode_q <= dnode_d;
            err_q   <= err_d;
            pack_q  <= pack_d;
            dack_q  <= dack_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ndump_q <= ndump_d;
        end
    end

    // Message payload is taken straight from registers so it is stable while valid.
    always_comb begin
        msg_valid = 1'b0;
        msg_kind  = 1'b0;
        msg_city  = '0;
        msg_type  = '0;
        if (state_q == StPMsg) begin
            msg_valid = 1'b1;
            msg_city  = pcity_q;
            msg_type  = ascii_of(pty_q);
        end else if (state_q == StDMsg) begin
            msg_valid = 1'b1;
            msg_kind  = 1'b1;
            msg_city  = city_q[msg_idx];
            msg_type  = ascii_of(ty_q[msg_idx]);
        end
    end

    assign busy      = (state_q != StIdle);
    assign pick_ack  = pack_q;
    assign drop_ack  = dack_q;
    assign err       = err_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign next_dump = ndump_q;
    assign cmd_arm   = arm_q;
    assign cmd_grip  = grip_q;

endmodule

// File: tb/tb_sb_cargo_manager.sv
// Directed bench for sb_cargo_manager with a message scoreboard.
module tb_sb_cargo_manager;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pick_req, drop_req, msg_ready;
    logic [2:0] pick_color;
    logic [7:0] pick_city;
    logic [4:0] drop_node;
    logic       pick_ack, drop_ack, err, busy, full, empty;
    logic [3:0] count;
    logic [4:0] next_dump;
    logic [1:0] cmd_arm, cmd_grip;
    logic       msg_valid, msg_kind;
    logic [7:0] msg_city, msg_type;

    typedef struct packed {
        logic       kind;
        logic [7:0] city;
        logic [7:0] ty;
    } msg_t;

    msg_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pa_cnt, da_cnt, err_cnt;

    always #5 clk = ~clk;

    sb_cargo_manager #(
        .NUM_SLOTS(3), .NODE_W(5), .SERVO_WAIT(4),
        .DUMP_W(17), .DUMP_M(7), .DUMP_D(11)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pick_req(pick_req), .pick_color(pick_color), .pick_city(pick_city),
        .pick_ack(pick_ack),
        .drop_req(drop_req), .drop_node(drop_node), .drop_ack(drop_ack),
        .err(err), .busy(busy), .count(count), .full(full), .empty(empty),
        .next_dump(next_dump), .cmd_arm(cmd_arm), .cmd_grip(cmd_grip),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_kind(msg_kind),
        .msg_city(msg_city), .msg_type(msg_type)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop();
        msg_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_msg", 32'(msg_valid), 0);
        end else begin
            e = exp_q.pop_front();
            chk("msg_kind", 32'(msg_kind), 32'(e.kind));
            chk("msg_city", 32'(msg_city), 32'(e.city));
            chk("msg_type", 32'(msg_type), 32'(e.ty));
        end
    endtask

    // Drive a request for one cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic p, input logic [2:0] col, input logic [7:0] city,
                         input logic d, input logic [4:0] node);
        pick_req = p; pick_color = col; pick_city = city;
        drop_req = d; drop_node = node;
        @(negedge clk);
        pick_req = 1'b0; drop_req = 1'b0;
    endtask

    // Step n cycles, popping the scoreboard on handshakes and counting pulses.
    task automatic run(input int n);
        pa_cnt = 0; da_cnt = 0; err_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (msg_valid && msg_ready) sb_pop();
            if (pick_ack) pa_cnt++;
            if (drop_ack) da_cnt++;
            if (err) err_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_arm", 32'(cmd_arm), 1);
        chk("rst_grip", 32'(cmd_grip), 2);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_next_dump", 32'(next_dump), 0);
        chk("rst_msg_valid", 32'(msg_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        pick_req = 0; drop_req = 0; pick_color = 0; pick_city = 0; drop_node = 0;
        msg_ready = 1'b1;
        do_reset();

        // Cycle-accurate single pick: blue, city "3".
        exp_q.push_back('{kind: 1'b0, city: 8'h33, ty: 8'h57});
        issue(1'b1, 3'b001, 8'h33, 1'b0, 5'd0);
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("t1_arm_c%0d", k), 32'(cmd_arm), (k <= 8) ? 2 : 1);
            chk($sformatf("t1_grip_c%0d", k), 32'(cmd_grip), (k <= 4) ? 2 : 3);
            chk($sformatf("t1_valid_c%0d", k), 32'(msg_valid), (k == 13) ? 1 : 0);
            chk($sformatf("t1_pack_c%0d", k), 32'(pick_ack), (k == 14) ? 1 : 0);
            if (k == 13) sb_pop();
            if (k < 14) @(negedge clk);
        end
        chk("t1_count", 32'(count), 1);
        chk("t1_next_dump", 32'(next_dump), 17);
        chk("t1_busy", 32'(busy), 0);

        // Fill all three slots: M "1", D "2", W "4".
        do_reset();
        exp_q.push_back('{kind: 1'b0, city: 8'h31, ty: 8'h4D});
        issue(1'b1, 3'b100, 8'h31, 1'b0, 5'd0); run(16);
        exp_q.push_back('{kind: 1'b0, city: 8'h32, ty: 8'h44});
        issue(1'b1, 3'b010, 8'h32, 1'b0, 5'd0); run(16);
        exp_q.push_back('{kind: 1'b0, city: 8'h34, ty: 8'h57});
        issue(1'b1, 3'b001, 8'h34, 1'b0, 5'd0); run(16);
        chk("fill_pack", 32'(pa_cnt), 1);
        chk("fill_count", 32'(count), 3);
        chk("fill_full", 32'(full), 1);
        chk("fill_next_dump", 32'(next_dump), 7);
        chk("fill_sb_left", 32'(exp_q.size()), 0);

        // Fourth pick while full is rejected without motion.
        issue(1'b1, 3'b010, 8'h35, 1'b0, 5'd0);
        chk("full_err", 32'(err), 1);
        chk("full_busy", 32'(busy), 0);
        chk("full_arm", 32'(cmd_arm), 1);
        chk("full_grip", 32'(cmd_grip), 3);
        run(3);
        chk("full_count", 32'(count), 3);
        chk("full_no_ack", 32'(pa_cnt), 0);

        // Drop the wet block, then refill the hole with metal: M, D, M.
        exp_q.push_back('{kind: 1'b1, city: 8'h34, ty: 8'h57});
        issue(1'b0, 3'b000, 8'h00, 1'b1, 5'd17); run(18);
        chk("dw_dack", 32'(da_cnt), 1);
        chk("dw_count", 32'(count), 2);
        exp_q.push_back('{kind: 1'b0, city: 8'h36, ty: 8'h4D});
        issue(1'b1, 3'b100, 8'h36, 1'b0, 5'd0); run(16);
        chk("hole_count", 32'(count), 3);

        // Drop at 7 with a simultaneous pick: two DROP messages, pick ignored.
        exp_q.push_back('{kind: 1'b1, city: 8'h31, ty: 8'h4D});
        exp_q.push_back('{kind: 1'b1, city: 8'h36, ty: 8'h4D});
        issue(1'b1, 3'b010, 8'h39, 1'b1, 5'd7); run(20);
        chk("dm_dack", 32'(da_cnt), 1);
        chk("dm_pack", 32'(pa_cnt), 0);
        chk("dm_err", 32'(err_cnt), 0);
        chk("dm_sb_left", 32'(exp_q.size()), 0);
        chk("dm_count", 32'(count), 1);
        chk("dm_next_dump", 32'(next_dump), 11);

        // Drop with no match: err and drop_ack together, no motion.
        issue(1'b0, 3'b000, 8'h00, 1'b1, 5'd3);
        chk("nm_err", 32'(err), 1);
        chk("nm_dack", 32'(drop_ack), 1);
        chk("nm_busy", 32'(busy), 0);
        @(negedge clk);
        chk("nm_err_clr", 32'(err), 0);
        chk("nm_dack_clr", 32'(drop_ack), 0);

        // Stalled handshake: pick W "8" with msg_ready low.
        msg_ready = 1'b0;
        issue(1'b1, 3'b001, 8'h38, 1'b0, 5'd0);
        for (int i = 0; i < 40 && !msg_valid; i++) @(negedge clk);
        chk("st_valid_seen", 32'(msg_valid), 1);
        exp_q.push_back('{kind: 1'b0, city: 8'h38, ty: 8'h57});
        for (int i = 0; i < 20; i++) begin
            chk("st_valid", 32'(msg_valid), 1);
            chk("st_kind", 32'(msg_kind), 0);
            chk("st_city", 32'(msg_city), 'h38);
            chk("st_type", 32'(msg_type), 'h57);
            chk("st_pack", 32'(pick_ack), 0);
            chk("st_arm", 32'(cmd_arm), 1);
            chk("st_grip", 32'(cmd_grip), 3);
            @(negedge clk);
        end
        msg_ready = 1'b1;
        sb_pop();
        @(negedge clk);
        chk("st_pack_rise", 32'(pick_ack), 1);
        chk("st_valid_drop", 32'(msg_valid), 0);
        chk("st_count", 32'(count), 2);
        chk("st_next_dump", 32'(next_dump), 17);

        // Invalid colour 011.
        issue(1'b1, 3'b011, 8'h37, 1'b0, 5'd0);
        chk("ic_err", 32'(err), 1);
        chk("ic_busy", 32'(busy), 0);
        chk("ic_arm", 32'(cmd_arm), 1);
        @(negedge clk);
        chk("ic_err_clr", 32'(err), 0);
        chk("ic_count", 32'(count), 2);

        // Reset during D_RELEASE aborts the drop.
        issue(1'b0, 3'b000, 8'h00, 1'b1, 5'd11);
        repeat (5) @(negedge clk);
        chk("rr_grip_release", 32'(cmd_grip), 2);
        chk("rr_arm_down", 32'(cmd_arm), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_arm", 32'(cmd_arm), 1);
        chk("rr_grip", 32'(cmd_grip), 2);
        chk("rr_count", 32'(count), 0);
        chk("rr_msg_valid", 32'(msg_valid), 0);
        chk("rr_dack", 32'(drop_ack), 0);
        chk("rr_busy", 32'(busy), 0);
        rst_n = 1'b1;
        run(20);
        chk("rr_no_dack", 32'(da_cnt), 0);
        chk("rr_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_cargo_manager.md
Name: sb_cargo_manager

Overview:
- Parametrised successor to the top-level block-collect logic. Tracks up to NUM_SLOTS collected garbage blocks (type, city, dump node) and sequences arm and gripper servo commands for pick and drop.
- Issues PICK/DROP message requests to the UART formatter over a valid/ready handshake.
- Sits between the navigation FSM, which issues pick/drop requests, and the servo and UART modules.

Parameters:
- NUM_SLOTS, 3: cargo capacity, 1..8.
- NODE_W, 5: node number width.
- SERVO_WAIT, 40000000: clocks per servo motion step, at least 1.
- DUMP_W, 17: dump node for wet (blue).
- DUMP_M, 7: dump node for metal (red).
- DUMP_D, 11: dump node for dry (green).

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous active-low reset
- pick_req  in  1  request pick of block under gripper; sampled only in IDLE
- pick_color  in  3  colour code: 001 blue, 010 green, 100 red
- pick_city  in  8  ASCII city number of block
- pick_ack  out  1  one-cycle pulse, pick finished
- drop_req  in  1  request drop at current node; sampled only in IDLE
- drop_node  in  NODE_W  current node number
- drop_ack  out  1  one-cycle pulse, drop finished
- err  out  1  one-cycle pulse, request rejected
- busy  out  1  high whenever state is not IDLE
- count  out  4  occupied slots
- full  out  1  count == NUM_SLOTS
- empty  out  1  count == 0
- next_dump  out  NODE_W  dump node of lowest-index occupied slot; 0 when empty
- cmd_arm  out  2  arm servo command: 01 up, 10 down
- cmd_grip  out  2  gripper servo command: 10 open, 11 closed
- msg_valid  out  1  message request
- msg_ready  in  1  UART formatter accepts message
- msg_kind  out  1  0 PICK, 1 DROP
- msg_city  out  8  ASCII city of block
- msg_type  out  8  ASCII type: "W", "M" or "D"

Behaviour:
- Reset (rst_n low at a clk edge):
  - all slots invalid; state IDLE; count 0; empty 1; full 0; next_dump 0.
  - cmd_arm 01; cmd_grip 10.
  - msg_valid, pick_ack, drop_ack, err all 0.
  - Reset mid-sequence aborts it immediately; no ack is given.
- Colour map: 001 -> "W"/DUMP_W; 100 -> "M"/DUMP_M; 010 -> "D"/DUMP_D. Any other code is invalid.
- States: IDLE, P_LOWER, P_GRIP, P_LIFT, P_MSG, D_LOWER, D_RELEASE, D_LIFT, D_MSG.
- Each motion state lasts exactly SERVO_WAIT cycles, counted by a 32-bit counter cleared on state entry.
- IDLE accepts one request per edge. Priority:
  - drop_req before pick_req;
  - pick_req with full=1 or an invalid colour -> err pulse, stay IDLE;
  - drop_req with no slot whose dump equals drop_node -> err and drop_ack pulse together next cycle, no motion.
- Pick sequence:
  - On accept, pick_color and pick_city are latched.
  - P_LOWER: cmd_arm 10, cmd_grip 10.
  - P_GRIP: cmd_grip 11.
  - P_LIFT: cmd_arm 01.
  - P_MSG: msg_valid 1, kind 0, latched city and type.
  - On the msg_valid & msg_ready edge: lowest free slot is written, count increments, state returns to IDLE, pick_ack is high the following cycle.
  - Latency with msg_ready tied high: request sampled at cycle 0 -> msg_valid in cycle 3*SERVO_WAIT+1, pick_ack in cycle 3*SERVO_WAIT+2.
- Drop sequence:
  - D_LOWER: cmd_arm 10.
  - D_RELEASE: cmd_grip 10.
  - D_LIFT: cmd_arm 01.
  - D_MSG: one message per matching slot, in ascending slot index, kind 1.
  - Each slot is cleared and count decremented at its own handshake edge.
  - drop_ack pulses the cycle after the last handshake.
- Message handshake:
  - msg_city, msg_type and msg_kind are held stable while msg_valid=1.
  - msg_valid drops on the cycle after a handshake unless another D_MSG message follows, in which case it stays high with new data.
  - Stalling msg_ready holds the state indefinitely; servo commands stay unchanged.
- Flags:
  - full, empty, count and next_dump are registered and update the cycle after a slot write or clear.
  - Slots are not compacted: a freed hole is reused first.
- Ignored inputs: pick_req and drop_req while busy are ignored with no err. Input values outside IDLE are don't-care.

Test Plan:
- SERVO_WAIT=4, msg_ready=1, pick_req at cycle 0 with colour 001, city "3" -> cmd_arm 10 during cycles 1-4, cmd_grip 11 from cycle 5, cmd_arm 01 from cycle 9, msg_valid cycle 13 carrying kind 0/"3"/"W", pick_ack cycle 14, count 1, next_dump 17.
- Three picks with colours 100, 010, 001, then a fourth pick -> full=1; fourth gives err pulse, no servo change, count stays 3.
- Slots hold M(7), D(11), M(7); drop_req with drop_node=7 -> two DROP messages from slots 0 then 2, drop_ack after the second, count 1, next_dump 11.
- drop_req and pick_req asserted together in IDLE with a matching slot -> drop runs, pick ignored; drop_req with drop_node=3 (no match) -> err and drop_ack pulse, no motion.
- msg_ready held 0 for 20 cycles during P_MSG -> msg_valid and data stable, no ack; ack arrives 1 cycle after msg_ready rises. Invalid colour 011 -> err only.
- rst_n low during D_RELEASE -> next cycle cmd_arm 01, cmd_grip 10, count 0, msg_valid 0, no drop_ack.
